simon_seq_game: RTL

- Parametrised successor to the single-round Simon Says top level: a full memory-sequence Simon game engine.
- Each round appends one pseudo-random button index to a stored sequence, plays the whole sequence back on one-hot lamps, then checks the player's key presses in order against it.
- Sits between the key scanner (strobe plus key code) and the display/LED glue.
- Generalised over button count, maximum sequence length and all timing; adds per-press timeout and a win condition.

---
 rtl/simon_seq_game.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/simon_seq_game.sv
// Memory-sequence Simon game engine: grows a pseudo-random button sequence each round,
// plays it back on one-hot lamps and checks the player's key strobes against it.
module simon_seq_game #(
  parameter int         NUM_BTNS      = 4,
  parameter int         MAX_LEN       = 16,
  parameter int         SHOW_TICKS    = 50,
  parameter int         GAP_TICKS     = 25,
  parameter int         TIMEOUT_TICKS = 500,
  parameter int         RESULT_TICKS  = 100,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input  logic                hz100,
  input  logic                reset_n,
  input  logic                start,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  output logic [NUM_BTNS-1:0] lamp,
  output logic [5:0]          score,
  output logic [2:0]          state,
  output logic                red,
  output logic                green
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHOW  = 3'd1,
    S_GAP   = 3'd2,
    S_INPUT = 3'd3,
    S_PASS  = 3'd4,
    S_FAIL  = 3'd5,
    S_WIN   = 3'd6
  } state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int EW   = $clog2(NUM_BTNS);
  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = max4(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS, RESULT_TICKS);
  localparam int TW   = $clog2(TMAX + 1);

  function automatic logic [NUM_BTNS-1:0] onehot(input logic [EW-1:0] e);
    onehot    = '0;
    onehot[e] = 1'b1;
  endfunction

  state_t        st;
  logic [7:0]    lfsr;
  logic [5:0]    len;
  logic [5:0]    idx;
  logic [TW-1:0] timer;
  logic [EW-1:0] seq [2**AW];

  logic [5:0]    idx_nxt;
  logic [EW-1:0] new_elem;
  logic [EW-1:0] cur_elem;
  logic [EW-1:0] nxt_elem;
  logic [EW-1:0] first_elem;
  logic          timer_zero;
  logic          last;
  logic          key_ok;
  logic          start_ok;
  logic          seq_we;
  logic [AW-1:0] seq_waddr;

  assign state      = st;
  assign idx_nxt    = idx + 6'd1;
  assign new_elem   = EW'(lfsr % NUM_BTNS);
  assign cur_elem   = seq[idx[AW-1:0]];
  assign nxt_elem   = seq[idx_nxt[AW-1:0]];
  assign first_elem = seq['0];
  assign timer_zero = (timer == '0);
  assign last       = (idx == len - 6'd1);
  // Out-of-range codes never match, so they fall through to FAIL.
  assign key_ok     = (key_code < 5'(NUM_BTNS)) && (key_code[EW-1:0] == cur_elem);
  assign start_ok   = start && ((st == S_IDLE) || (st == S_WIN));

  // Appends happen on a new game (slot 0) and when PASS hands over to the next round.
  assign seq_we    = start_ok || ((st == S_PASS) && timer_zero);
  assign seq_waddr = start_ok ? '0 : len[AW-1:0];

  always_ff @(posedge hz100) begin
    if (seq_we) seq[seq_waddr] <= new_elem;
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      st    <= S_IDLE;
      lfsr  <= SEED;
      len   <= '0;
      idx   <= '0;
      timer <= '0;
      score <= '0;
      lamp  <= '0;
      red   <= 1'b0;
      green <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (st)
        S_IDLE, S_WIN: begin
          if (start) begin
            len   <= 6'd1;
            idx   <= '0;
            score <= '0;
            timer <= TW'(SHOW_TICKS - 1);
            lamp  <= onehot(new_elem);
            red   <= 1'b0;
            green <= 1'b0;
            st    <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (timer_zero) begin
            timer <= TW'(GAP_TICKS - 1);
            lamp  <= '0;
            st    <= S_GAP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_GAP: begin
          if (timer_zero) begin
            if (last) begin
              idx   <= '0;
              timer <= TW'(TIMEOUT_TICKS - 1);
              st    <= S_INPUT;
            end else begin
              idx   <= idx_nxt;
              timer <= TW'(SHOW_TICKS - 1);
              lamp  <= onehot(nxt_elem);
              st    <= S_SHOW;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_INPUT: begin
          // A key arriving on the timeout cycle wins over the timeout.
          if (key_valid) begin
            if (!key_ok) begin
              timer <= TW'(RESULT_TICKS - 1);
              red   <= 1'b1;
              st    <= S_FAIL;
            end else if (!last) begin
              idx   <= idx_nxt;
              timer <= TW'(TIMEOUT_TICKS - 1);
            end else if (len < 6'(MAX_LEN)) begin
              score <= score + 6'd1;
              timer <= TW'(RESULT_TICKS - 1);
              green <= 1'b1;
              st    <= S_PASS;
            end else begin
              score <= score + 6'd1;
              green <= 1'b1;
              st    <= S_WIN;
            end
          end else if (timer_zero) begin
            timer <= TW'(RESULT_TICKS - 1);
            red   <= 1'b1;
            st    <= S_FAIL;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_PASS: begin
          if (timer_zero) begin
            len   <= len + 6'd1;
            idx   <= '0;
            timer <= TW'(SHOW_TICKS - 1);
            lamp  <= onehot(first_elem);
            green <= 1'b0;
            st    <= S_SHOW;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_FAIL: begin
          if (timer_zero) begin
            red <= 1'b0;
            st  <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
